cpu_fetch_queue: RTL and testbench
==================================

# cpu_fetch_queue

Instruction prefetch queue between the instruction-bus fetch unit and the decode stage's skid buffer. Accepts fetched {pc, instruction} pairs, buffers up to DEPTH entries, and presents the oldest entry downstream under the same `i_busy` stall convention the decode-side skid buffer uses. A flush input discards all buffered entries on branch or trap redirect.

## Interface
Parameters:
- `DW`, 32, instruction word width.
- `AW`, 32, PC width.
- `DEPTH`, 4, entry count; power of two, ≥ 2.

Ports:
- `i_clock`  in  1  sole clock; all state on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_flush`  in  1  discard all entries this cycle.
- `i_push_valid`  in  1  fetch unit offers an entry.
- `i_push_pc`  in  AW  PC of offered instruction.
- `i_push_data`  in  DW  offered instruction word.
- `o_push_ready`  out  1  queue can accept; equals !full.
- `o_valid`  out  1  head entry available.
- `o_pc`  out  AW  head PC.
- `o_data`  out  DW  head instruction.
- `i_busy`  in  1  downstream stall; head is held while high.
- `o_count`  out  $clog2(DEPTH+1)  entries held.

## Operation
- Push accepted when `i_push_valid && o_push_ready && !i_flush`. Entry written at write pointer; write pointer advances.
- Pop occurs when `o_valid && !i_busy && !i_flush`. Read pointer advances.
- Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Empty when pointers are equal. Full when MSBs differ and the low bits are equal. Pointers wrap modulo 2·DEPTH.
- `o_count` = wptr − rptr (modulo 2·DEPTH) and ranges 0..DEPTH.
- Simultaneous push and pop, not full: both occur; count is unchanged.
- Full with pop in the same cycle: push is still rejected. `o_push_ready` never depends on `i_busy`, so there is no combinational path from `i_busy` to `o_push_ready`.
- Flush has priority over push and pop. Next cycle: pointers are 0, count is 0, `o_valid` is 0. A push offered in the flush cycle is dropped.
- `o_pc`/`o_data` are driven combinationally from the head storage slot. They are don't-care while `o_valid` is 0 but must not be X after reset.
- No state machine beyond the pointer pair.

## Timing
- Reset (async assert, sync-safe deassert by system): pointers are 0 and storage is zeroed, giving `o_valid`=0, `o_push_ready`=1, `o_count`=0, `o_pc`=0, `o_data`=0.
- Push-to-output latency is 1 cycle, baseline build.
- Head is held stable for every cycle that `i_busy` is high.
- Throughput is one push and one pop per cycle sustained.
- Reset asserted mid-operation forces the reset state immediately. Contents are lost.

## Configuration
Macro: `CPU_FETCH_QUEUE_BYPASS_EN`.
- Defined, with the queue empty and no flush:
  - `o_valid`=`i_push_valid` and `o_pc`/`o_data` = push inputs, so latency is 0.
  - If `!i_busy`, the entry is consumed without being written: pointers are unchanged and count stays 0.
  - If `i_busy`, the entry is written normally.
- Not defined: latency 1, no combinational path from push inputs to outputs.
- All other behaviour is identical in both builds.

## Structure
- Shared package `CPU_Defines`: `fetch_entry_t` packed struct {pc[AW], data[DW]} and the DEPTH-derived pointer width function.
- One sub-module: `cpu_fetch_queue_mem`, a DEPTH×(AW+DW) register array.
  - One write port.
  - One asynchronous read port.
  - Async active-low clear.
- Pointer and flag logic stays in the top.

## Test plan
- Reset, then push PCs 0x100, 0x104, 0x108, 0x10C with `i_busy`=1 → `o_count`=4, `o_push_ready`=0. A fifth push of 0x110 is ignored and the head stays 0x100.
- From full, drop `i_busy` for 4 cycles → pops 0x100..0x10C in order, `o_count` goes 3, 2, 1, 0, then `o_valid`=0.
- Sustained push and pop every cycle for 20 entries with `i_busy`=0 and pointers wrapping several times → outputs in order, no loss, `o_count` constant at 1 (baseline) or 0 (bypass).
- With 3 entries held, assert `i_flush` together with push 0x200 → next cycle `o_count`=0 and `o_valid`=0. 0x200 never appears.
- Bypass build, empty queue, push 0x300 with `i_busy`=0 → `o_valid`=1 and `o_pc`=0x300 in the same cycle, with `o_count` still 0 afterwards. Repeat with `i_busy`=1 → `o_count`=1 and the head is 0x300.
- Assert `i_reset` low asynchronously mid-burst with 2 entries held → outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/cpu_fetch_queue_pkg.sv
//==============================================================================
// Module  : CPU_Defines (package)
// Brief   : Shared types and helpers for the instruction prefetch queue.
//           fetch_entry_t documents the {pc, data} slot layout used by the
//           queue storage (pc in the upper bits, instruction in the lower).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package CPU_Defines;

    localparam int CPU_AW = 32;
    localparam int CPU_DW = 32;

    // One buffered fetch: PC in the upper bits, instruction word below it.
    typedef struct packed {
        logic [CPU_AW-1:0] pc;
        logic [CPU_DW-1:0] data;
    } fetch_entry_t;

    // Pointer width for a power-of-two depth: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_fetch_queue_mem.sv
//==============================================================================
// Module  : cpu_fetch_queue_mem
// Brief   : DEPTH x WIDTH register array for the fetch queue. One write port,
//           one asynchronous read port, asynchronous active-low clear.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [IW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [IW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] slots [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_q;
            logic [WIDTH-1:0] entry_d;

            // Load this slot only when the write port addresses it.
            always_comb begin
                entry_d = entry_q;
                if (i_we && (i_waddr == IW'(gi))) begin
                    entry_d = i_wdata;
                end
            end

            // Slot register; cleared so the read port never shows X.
            always_ff @(posedge i_clock or negedge i_reset) begin
                if (!i_reset) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign slots[gi] = entry_q;
        end
    endgenerate

    // Asynchronous read of the addressed slot.
    always_comb begin
        o_rdata = slots[i_raddr];
    end

endmodule

`default_nettype wire

// File: rtl/cpu_fetch_queue.sv
//==============================================================================
// Module  : cpu_fetch_queue
// Brief   : Instruction prefetch queue between the fetch unit and decode.
//           Buffers up to DEPTH {pc, instruction} pairs, presents the oldest
//           under the i_busy stall convention, flush discards everything.
//           Optional macro CPU_FETCH_QUEUE_BYPASS_EN: when the queue is empty
//           the offered entry is presented in the same cycle, and consumed
//           without being stored if downstream is not busy.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_fetch_queue
    import CPU_Defines::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_push_valid,
    input  logic [AW-1:0]              i_push_pc,
    input  logic [DW-1:0]              i_push_data,
    output logic                       o_push_ready,
    output logic                       o_valid,
    output logic [AW-1:0]              o_pc,
    output logic [DW-1:0]              o_data,
    input  logic                       i_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int IW = PW - 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = AW + DW;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;

    logic          w_empty;
    logic          w_full;
    logic          w_push_fire;
    logic          w_pop_fire;
    logic          w_write;
    logic          w_read;
    logic [EW-1:0] w_head;
    logic [PW-1:0] w_diff;

    // Storage for the buffered entries; head is read combinationally.
    cpu_fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .IW    (IW)
    ) u_mem (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_we    (w_write),
        .i_waddr (wptr_q[IW-1:0]),
        .i_wdata ({i_push_pc, i_push_data}),
        .i_raddr (rptr_q[IW-1:0]),
        .o_rdata (w_head)
    );

    // Occupancy flags from the wrap-bit pointer pair.
    always_comb begin
        w_empty      = (wptr_q == rptr_q);
        w_full       = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                       (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
        w_diff       = wptr_q - rptr_q;
        o_count      = CW'(w_diff);
        o_push_ready = !w_full;
    end

    // Head presentation and the push/pop qualification for this cycle.
    always_comb begin
        w_push_fire = i_push_valid && !w_full && !i_flush;
`ifdef CPU_FETCH_QUEUE_BYPASS_EN
        if (w_empty && !i_flush) begin
            o_valid = i_push_valid;
            o_pc    = i_push_pc;
            o_data  = i_push_data;
        end else begin
            o_valid = !w_empty;
            o_pc    = w_head[EW-1:DW];
            o_data  = w_head[DW-1:0];
        end
        w_pop_fire = o_valid && !i_busy && !i_flush;
        // A bypassed entry taken downstream never touches the storage.
        w_write    = w_push_fire && !(w_empty && !i_busy);
        w_read     = w_pop_fire && !w_empty;
`else
        o_valid    = !w_empty;
        o_pc       = w_head[EW-1:DW];
        o_data     = w_head[DW-1:0];
        w_pop_fire = o_valid && !i_busy && !i_flush;
        w_write    = w_push_fire;
        w_read     = w_pop_fire;
`endif
    end

    // Pointer advance; flush takes priority and returns both to zero.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (w_write) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (w_read) begin
                rptr_d = rptr_q + PW'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch_queue.sv
//==============================================================================
// Module  : tb_cpu_fetch_queue
// Brief   : Self-checking bench for cpu_fetch_queue: vector table of
//           per-cycle stimulus and expected state, with a scoreboard of
//           accepted entries compared as the queue hands them downstream.
//           Expectations follow CPU_FETCH_QUEUE_BYPASS_EN when it is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_fetch_queue;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef CPU_FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          i_clock;
    logic          i_reset;
    logic          i_flush;
    logic          i_push_valid;
    logic [AW-1:0] i_push_pc;
    logic [DW-1:0] i_push_data;
    logic          o_push_ready;
    logic          o_valid;
    logic [AW-1:0] o_pc;
    logic [DW-1:0] o_data;
    logic          i_busy;
    logic [CW-1:0] o_count;

    cpu_fetch_queue #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_flush      (i_flush),
        .i_push_valid (i_push_valid),
        .i_push_pc    (i_push_pc),
        .i_push_data  (i_push_data),
        .o_push_ready (o_push_ready),
        .o_valid      (o_valid),
        .o_pc         (o_pc),
        .o_data       (o_data),
        .i_busy       (i_busy),
        .o_count      (o_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic          pv;
        logic [AW-1:0] pc;
        logic          busy;
        logic          flush;
        int            exp_count;
        logic          exp_ready;
        logic          exp_valid;
        logic [AW-1:0] exp_head;
    } vec_t;

    vec_t vecs [64];
    int   n_vecs;

    int   checks;
    int   failures;
    int   m_count;
    logic [AW+DW-1:0] sb [$];

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    function automatic void add(input logic pv, input logic [AW-1:0] pc,
                                input logic busy, input logic flush,
                                input int cnt, input logic rdy,
                                input logic vld, input logic [AW-1:0] head);
        vecs[n_vecs] = '{pv, pc, busy, flush, cnt, rdy, vld, head};
        n_vecs++;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, entered at posedge+2 and left at posedge+2.
    task automatic drive_cycle(input logic pv, input logic [AW-1:0] pc,
                               input logic busy, input logic flush);
        logic accept, pop, exp_valid;
        logic [AW+DW-1:0] e;
        i_push_valid = pv;
        i_push_pc    = pc;
        i_push_data  = data_of(pc);
        i_busy       = busy;
        i_flush      = flush;
        #3;
        accept = pv && (m_count < DEPTH) && !flush;
        if (accept) sb.push_back({pc, data_of(pc)});
        exp_valid = (m_count > 0) || (BYP && (m_count == 0) && pv && !flush);
        check("valid_pre", 64'(o_valid), 64'(exp_valid));
        check("ready_pre", 64'(o_push_ready), 64'(m_count < DEPTH));
        pop = exp_valid && !busy && !flush;
        if (pop) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=pop required=no_pop at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("pop_pc", 64'(o_pc), 64'(e[AW+DW-1:DW]));
                check("pop_data", 64'(o_data), 64'(e[DW-1:0]));
            end
        end
        @(posedge i_clock);
        #1;
        if (flush) begin
            m_count = 0;
            sb.delete();
        end else begin
            m_count = m_count + int'(accept) - int'(pop);
        end
        i_push_valid = 1'b0;
        i_flush      = 1'b0;
        #1;
        check("count_model", 64'(o_count), 64'(m_count));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_count  = 0;
        n_vecs   = 0;

        // Fill to full while stalled; the fifth push must bounce.
        add(1, 32'h100, 1, 0, 1, 1, 1, 32'h100);
        add(1, 32'h104, 1, 0, 2, 1, 1, 32'h100);
        add(1, 32'h108, 1, 0, 3, 1, 1, 32'h100);
        add(1, 32'h10C, 1, 0, 4, 0, 1, 32'h100);
        add(1, 32'h110, 1, 0, 4, 0, 1, 32'h100);
        // Drain in order.
        add(0, 32'h0,   0, 0, 3, 1, 1, 32'h104);
        add(0, 32'h0,   0, 0, 2, 1, 1, 32'h108);
        add(0, 32'h0,   0, 0, 1, 1, 1, 32'h10C);
        add(0, 32'h0,   0, 0, 0, 1, 0, 32'h0);
        // Three held, then flush with a competing push.
        add(1, 32'h500, 1, 0, 1, 1, 1, 32'h500);
        add(1, 32'h504, 1, 0, 2, 1, 1, 32'h500);
        add(1, 32'h508, 1, 0, 3, 1, 1, 32'h500);
        add(1, 32'h200, 1, 1, 0, 1, 0, 32'h0);
        add(1, 32'h204, 0, 0, BYP ? 0 : 1, 1, !BYP, 32'h204);
        add(0, 32'h0,   0, 0, 0, 1, 0, 32'h0);
        // Sustained push+pop; 22 pointer moves wrap mod 8 several times.
        add(1, 32'h400, 0, 0, BYP ? 0 : 1, 1, !BYP, 32'h400);
        for (int k = 1; k <= 20; k++) begin
            add(1, 32'h400 + 32'(4 * k), 0, 0, BYP ? 0 : 1, 1, !BYP,
                32'h400 + 32'(4 * k));
        end
        add(0, 32'h0,   0, 0, 0, 1, 0, 32'h0);
`ifdef CPU_FETCH_QUEUE_BYPASS_EN
        // Bypass: consumed with no storage, then stored when stalled.
        add(1, 32'h300, 0, 0, 0, 1, 0, 32'h0);
        add(1, 32'h300, 1, 0, 1, 1, 1, 32'h300);
        add(0, 32'h0,   0, 0, 0, 1, 0, 32'h0);
`endif

        i_reset      = 1'b0;
        i_flush      = 1'b0;
        i_push_valid = 1'b0;
        i_push_pc    = '0;
        i_push_data  = '0;
        i_busy       = 1'b0;
        repeat (2) @(posedge i_clock);
        #3;
        i_reset = 1'b1;
        @(posedge i_clock);
        #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_push_ready), 64'd1);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_pc", 64'(o_pc), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);

        for (int v = 0; v < n_vecs; v++) begin
            drive_cycle(vecs[v].pv, vecs[v].pc, vecs[v].busy, vecs[v].flush);
            check("vec_count", 64'(o_count), 64'(vecs[v].exp_count));
            check("vec_ready", 64'(o_push_ready), 64'(vecs[v].exp_ready));
            check("vec_valid", 64'(o_valid), 64'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                check("vec_head", 64'(o_pc), 64'(vecs[v].exp_head));
                check("vec_hdata", 64'(o_data), 64'(data_of(vecs[v].exp_head)));
            end
        end

        // Asynchronous reset mid-burst with two entries held.
        drive_cycle(1, 32'h600, 1, 0);
        drive_cycle(1, 32'h604, 1, 0);
        check("pre_rst_count", 64'(o_count), 64'd2);
        i_push_pc   = '0;
        i_push_data = '0;
        #1;
        i_reset = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_ready", 64'(o_push_ready), 64'd1);
        check("arst_count", 64'(o_count), 64'd0);
        check("arst_pc", 64'(o_pc), 64'd0);
        check("arst_data", 64'(o_data), 64'd0);
        m_count = 0;
        sb.delete();
        #2;
        i_reset = 1'b1;
        @(posedge i_clock);
        #2;
        drive_cycle(1, 32'h700, 1, 0);
        check("post_rst_head", 64'(o_pc), 64'h700);
        drive_cycle(0, 32'h0, 0, 0);
        check("post_rst_empty", 64'(o_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
